// File: rtl/bitfusion_pkg.sv
// rtl/bitfusion_pkg.sv - shared types and constants for the bitfusion MAC sequencer
package bitfusion_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_e;

  localparam int FU_LAT    = 2;
  localparam int TAG_DEPTH = FU_LAT + 1;

  localparam logic [3:0] W1 = 4'd1;
  localparam logic [3:0] W2 = 4'd2;
  localparam logic [3:0] W4 = 4'd4;
  localparam logic [3:0] W8 = 4'd8;

endpackage

// File: rtl/bitfusion_psum_acc.sv
// rtl/bitfusion_psum_acc.sv - extends returned psums and accumulates them with a beat count
module bitfusion_psum_acc
  import bitfusion_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sgn,
  input  logic [15:0]      psum,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt
);

  logic [ACC_W-1:0] acc_q, acc_d, ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ext   = sgn ? ACC_W'($signed(psum)) : ACC_W'(psum);
    acc_d = acc_q;
    cnt_d = cnt_q;
    // Clear wins; it only fires in HOLD, where no tag can be valid anyway.
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en) begin
      acc_d = acc_q + ext;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/bitfusion_mac_sequencer.sv
// rtl/bitfusion_mac_sequencer.sv - feeds operand pairs to bitfusion_top and accumulates psums per vector
module bitfusion_mac_sequencer
  import bitfusion_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_in,
  input  logic [7:0]       op_weight,
  input  logic             op_last,
  input  logic [3:0]       cfg_in_width,
  input  logic [3:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  output logic [7:0]       fu_in,
  output logic [7:0]       fu_weight,
  output logic [3:0]       fu_in_width,
  output logic [3:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  input  logic [15:0]      fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_count
);

  state_e               state_q, state_d;
  logic                 op_ready_q, op_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [7:0]           fu_in_q, fu_in_d, fu_weight_q, fu_weight_d;
  logic [3:0]           fu_in_width_q, fu_in_width_d, fu_weight_width_q, fu_weight_width_d;
  logic                 fu_s_in_q, fu_s_in_d, fu_s_weight_q, fu_s_weight_d;
  logic [TAG_DEPTH-1:0] tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic                 accept, res_fire;

  always_comb begin
    accept   = op_valid & op_ready_q;
    res_fire = res_valid_q & res_ready;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_last ? FLUSH : RUN;
      RUN:     if (accept && op_last) state_d = FLUSH;
      FLUSH:   if (tag_v_q[TAG_DEPTH-1] && tag_l_q[TAG_DEPTH-1]) state_d = HOLD;
      HOLD:    if (res_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    op_ready_d  = (state_d == IDLE) || (state_d == RUN);
    res_valid_d = (state_d == HOLD);

    // Config is captured only on the opening beat and then drives the unit for the whole vector.
    fu_in_width_d     = fu_in_width_q;
    fu_weight_width_d = fu_weight_width_q;
    fu_s_in_d         = fu_s_in_q;
    fu_s_weight_d     = fu_s_weight_q;
    if (accept && state_q == IDLE) begin
      fu_in_width_d     = cfg_in_width;
      fu_weight_width_d = cfg_weight_width;
      fu_s_in_d         = cfg_s_in;
      fu_s_weight_d     = cfg_s_weight;
    end

    fu_in_d     = accept ? op_in : 8'd0;
    fu_weight_d = accept ? op_weight : 8'd0;

    tag_v_d = {tag_v_q[TAG_DEPTH-2:0], accept};
    tag_l_d = {tag_l_q[TAG_DEPTH-2:0], accept & op_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      op_ready_q        <= 1'b1;
      res_valid_q       <= 1'b0;
      fu_in_q           <= '0;
      fu_weight_q       <= '0;
      fu_in_width_q     <= '0;
      fu_weight_width_q <= '0;
      fu_s_in_q         <= 1'b0;
      fu_s_weight_q     <= 1'b0;
      tag_v_q           <= '0;
      tag_l_q           <= '0;
    end else begin
      state_q           <= state_d;
      op_ready_q        <= op_ready_d;
      res_valid_q       <= res_valid_d;
      fu_in_q           <= fu_in_d;
      fu_weight_q       <= fu_weight_d;
      fu_in_width_q     <= fu_in_width_d;
      fu_weight_width_q <= fu_weight_width_d;
      fu_s_in_q         <= fu_s_in_d;
      fu_s_weight_q     <= fu_s_weight_d;
      tag_v_q           <= tag_v_d;
      tag_l_q           <= tag_l_d;
    end
  end

  // Stage TAG_DEPTH-1 lines up with the psum produced for that beat.
  bitfusion_psum_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (res_fire),
    .en   (tag_v_q[TAG_DEPTH-1]),
    .sgn  (fu_s_in_q | fu_s_weight_q),
    .psum (fu_psum),
    .acc  (res_data),
    .cnt  (res_count)
  );

  assign op_ready        = op_ready_q;
  assign res_valid       = res_valid_q;
  assign fu_in           = fu_in_q;
  assign fu_weight       = fu_weight_q;
  assign fu_in_width     = fu_in_width_q;
  assign fu_weight_width = fu_weight_width_q;
  assign fu_s_in         = fu_s_in_q;
  assign fu_s_weight     = fu_s_weight_q;

endmodule

// File: tb/tb_bitfusion_mac_sequencer.sv
// tb/tb_bitfusion_mac_sequencer.sv - randomized self-checking bench for bitfusion_mac_sequencer
module tb_bitfusion_mac_sequencer;
  import bitfusion_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, op_last;
  logic [7:0]  op_in, op_weight;
  logic [3:0]  cfg_in_width, cfg_weight_width;
  logic        cfg_s_in, cfg_s_weight;
  logic [7:0]  fu_in, fu_weight;
  logic [3:0]  fu_in_width, fu_weight_width;
  logic        fu_s_in, fu_s_weight;
  logic [15:0] fu_psum;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [15:0] res_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] va[$];
  logic [7:0] vw[$];

  always #5 clk = ~clk;

  bitfusion_mac_sequencer #(.ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_in(op_in), .op_weight(op_weight), .op_last(op_last),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
    .fu_in(fu_in), .fu_weight(fu_weight), .fu_in_width(fu_in_width), .fu_weight_width(fu_weight_width),
    .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight), .fu_psum(fu_psum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count)
  );

  // Stand-in for bitfusion_top at 8-bit widths: register in, register out.
  logic [7:0] st_in, st_w;
  logic       st_si, st_sw;

  function automatic logic [15:0] fu_mul(input logic [7:0] a, input logic [7:0] w,
                                         input logic sa, input logic sw);
    int x, y;
    x = sa ? int'($signed(a)) : int'(a);
    y = sw ? int'($signed(w)) : int'(w);
    return 16'(x * y);
  endfunction

  always_ff @(posedge clk) begin
    st_in   <= fu_in;
    st_w    <= fu_weight;
    st_si   <= fu_s_in;
    st_sw   <= fu_s_weight;
    fu_psum <= fu_mul(st_in, st_w, st_si, st_sw);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected per-beat contribution: the true mathematical product, mod 2^32.
  function automatic logic [31:0] ref_term(input logic [7:0] a, input logic [7:0] w,
                                           input bit si, input bit sw);
    int x, y;
    x = (si && a >= 8'd128) ? int'(a) - 256 : int'(a);
    y = (sw && w >= 8'd128) ? int'(w) - 256 : int'(w);
    return 32'(x * y);
  endfunction

  task automatic send_vector(input bit si, input bit sw, input int gap, input int bp);
    logic [31:0] exp_sum, held;
    int n, edges;
    n = va.size();
    exp_sum = 0;
    cfg_in_width = W8; cfg_weight_width = W8; cfg_s_in = si; cfg_s_weight = sw;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          op_valid = 1'b0; op_in = 8'($urandom); op_weight = 8'($urandom);
          @(posedge clk); #1;
          check("bubble_fu_in", fu_in, 0);
          check("bubble_fu_weight", fu_weight, 0);
        end
      end
      op_valid = 1'b1; op_in = va[i]; op_weight = vw[i]; op_last = (i == n - 1);
      check("op_ready_beat", op_ready, 1);
      @(posedge clk); #1;
      check("fu_in", fu_in, va[i]);
      check("fu_weight", fu_weight, vw[i]);
      check("fu_in_width_latched", fu_in_width, W8);
      check("fu_s_in_latched", fu_s_in, si);
      check("fu_s_weight_latched", fu_s_weight, sw);
      exp_sum = exp_sum + ref_term(va[i], vw[i], si, sw);
      cfg_in_width = W4; cfg_s_in = ~si; cfg_s_weight = ~sw;
    end
    op_valid = 1'b0; op_last = 1'b0;
    edges = 0;
    check("res_valid_early", res_valid, 0);
    while (!res_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, 3);
    check("res_data", res_data, exp_sum);
    check("res_count", res_count, n);
    held = res_data;
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      check("bp_res_valid", res_valid, 1);
      check("bp_op_ready", op_ready, 0);
      check("bp_res_data", res_data, held);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("op_ready_after_hs", op_ready, 1);
    check("res_valid_after_hs", res_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_in = '0; op_weight = '0; op_last = 1'b0;
    cfg_in_width = '0; cfg_weight_width = '0; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready", op_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_fu_in", fu_in, 0);
    check("rst_fu_in_width", fu_in_width, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_count", res_count, 0);
    rst = 1'b0;

    va = '{8'd3, 8'd5}; vw = '{8'd4, 8'd6};
    send_vector(1'b0, 1'b0, 0, 0);
    va = '{8'hFF}; vw = '{8'h02};
    send_vector(1'b1, 1'b1, 0, 0);
    va = '{8'd3, 8'd5}; vw = '{8'd4, 8'd6};
    send_vector(1'b0, 1'b0, 2, 0);
    send_vector(1'b0, 1'b0, 0, 5);

    // Reset mid-vector: two beats in, reset lands on the third.
    cfg_in_width = W8; cfg_weight_width = W8; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_in = 8'd7; op_weight = 8'd9; op_last = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    check("midrst_op_ready", op_ready, 1);
    check("midrst_res_count", res_count, 0);
    check("midrst_fu_in", fu_in, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_res_valid", res_valid, 0);
    end
    va = '{8'd1}; vw = '{8'd1};
    send_vector(1'b0, 1'b0, 0, 0);

    for (int v = 0; v < 25; v++) begin
      int n;
      n = $urandom_range(1, 6);
      va.delete(); vw.delete();
      for (int i = 0; i < n; i++) begin
        va.push_back(8'($urandom));
        vw.push_back(8'($urandom));
      end
      send_vector(1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
